fetch_queue: RTL and testbench

- Parametrised multi-entry instruction queue between fetch and decode; successor to the single-stage fetch pipeline register.
- Buffers {pc, instr} pairs in order, with valid/ready handshakes on both sides, so fetch and decode can stall independently.
- Synchronous flush discards all entries on branch mispredict or redirect.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: an in-order circular buffer of
// {pc, instr} pairs with valid/ready handshakes on both sides and a
// synchronous flush for branch mispredicts and redirects.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [CNT_WIDTH-1:0]   count
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CountFull = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake signals come from registered occupancy only, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    in_ready  = (count_q != CountFull);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    pc_out    = pc_mem_q[rd_ptr_q];
    instr_out = instr_mem_q[rd_ptr_q];
    count     = count_q;
  end

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads 0 afterwards, but left
  // untouched by flush (the pointers alone make old entries unreachable).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      pc_mem_q[wr_ptr_q]    <= pc_in;
      instr_mem_q[wr_ptr_q] <= instr_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven fill/drain vectors plus
// hand-written multi-cycle sequences, with a scoreboard queue holding the
// expected {pc, instr} order.
module tb_fetch_queue;

  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] pc_in;
  logic [IW-1:0] instr_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] pc_out;
  logic [IW-1:0] instr_out;
  logic [CW-1:0] count;

  fetch_queue #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pc_out   (pc_out),
    .instr_out(instr_out),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  typedef struct {
    logic          iv;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          ordy;
    logic          fl;
    int            exp_cnt;
    logic          exp_ir;
    logic          exp_ov;
  } vec_t;

  ent_t sb[$];
  int   m_count;
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model at the falling edge,
  // then advance the model across the rising edge. exp_cnt < 0 skips the
  // explicit count/handshake expectation.
  task automatic cycle(input logic iv, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                       input logic ordy, input logic fl, input int exp_cnt,
                       input logic exp_ir, input logic exp_ov);
    logic m_push, m_pop;
    ent_t e;
    in_valid  = iv;
    pc_in     = pc;
    instr_in  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    chk("model_out_valid", 32'(out_valid), 32'(m_count != 0));
    if (exp_cnt >= 0) begin
      chk("vec_count", 32'(count), 32'(exp_cnt));
      chk("vec_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("vec_out_valid", 32'(out_valid), 32'(exp_ov));
    end
    // Head is compared whenever the model holds data: covers pops and
    // stability while stalled.
    if (m_count != 0) begin
      chk("head_pc", 32'(pc_out), 32'(sb[0].pc));
      chk("head_instr", instr_out, sb[0].instr);
    end
    m_push = iv && (m_count != DEPTH);
    m_pop  = ordy && (m_count != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (m_pop) begin
        void'(sb.pop_front());
        m_count--;
      end
      if (m_push) begin
        e.pc    = pc;
        e.instr = ins;
        sb.push_back(e);
        m_count++;
      end
    end
  endtask

  task automatic push_one(input logic [AW-1:0] pc, input logic [IW-1:0] ins);
    cycle(1'b1, pc, ins, 1'b0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, '0, '0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    total   = 0;
    bad     = 0;
    m_count = 0;

    // Fill to full (5th push refused), then drain in order.
    vecs[0] = '{1'b1, 12'h000, 32'hA0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 12'h004, 32'hA1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 12'h008, 32'hA2, 1'b0, 1'b0, 2, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 12'h00C, 32'hA3, 1'b0, 1'b0, 3, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 12'h010, 32'hA4, 1'b0, 1'b0, 4, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 12'h000, 32'h00, 1'b1, 1'b0, 4, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 12'h000, 32'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 12'h000, 32'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 12'h000, 32'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 12'h000, 32'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0};

    // Reset and idle.
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pc_in     = '0;
    instr_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_pc_out", 32'(pc_out), 32'd0);
    chk("idle_instr_out", instr_out, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl,
            vecs[i].exp_cnt, vecs[i].exp_ir, vecs[i].exp_ov);
    end

    // Streaming: count settles at 1 after the first cycle.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, AW'(12'h200 + 4 * i), 32'hB000 + 32'(i), 1'b1, 1'b0,
            (i == 0) ? 0 : 1, 1'b1, (i != 0));
    end
    pop_one();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Full with simultaneous pop: pop only, then the pending push lands.
    for (int i = 0; i < DEPTH; i++) push_one(AW'(12'h300 + 4 * i), 32'hC0 + 32'(i));
    cycle(1'b1, 12'h310, 32'hC4, 1'b1, 1'b0, 4, 1'b0, 1'b1);
    cycle(1'b1, 12'h310, 32'hC4, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    repeat (DEPTH) pop_one();

    // Flush with concurrent push and pop at count=3.
    for (int i = 0; i < 3; i++) push_one(AW'(12'h400 + 4 * i), 32'hD0 + 32'(i));
    cycle(1'b1, 12'h40C, 32'hD3, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    cycle(1'b1, 12'h100, 32'hE0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset between edges with count=2.
    push_one(12'h500, 32'hF0);
    push_one(12'h504, 32'hF1);
    in_valid = 1'b0;
    #2;
    chk("pre_arst_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal operation from empty after release.
    push_one(12'h600, 32'h1234);
    cycle(1'b1, 12'h604, 32'h5678, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    pop_one();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
